// File: rtl/uart_rx.sv
// uart_rx: UART receiver with a 2-flop input synchronizer and a valid/ready holding register.
// Optional macro UART_RX_PARITY_EN inserts an even-parity bit between data bit 7 and the stop bit.
module uart_rx #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  input  logic       ready_i,
  output logic       frame_err_o,
  output logic       overrun_o,
  output logic       parity_err_o,
  output logic       busy_o
);
  // state     | meaning
  // IDLE      | line idle, waiting for a falling edge
  // START     | counting to mid start bit; high line there is a glitch
  // DATA      | sampling 8 data bits, LSB first
  // PARITY    | sampling the even-parity bit (UART_RX_PARITY_EN only)
  // STOP      | sampling the stop bit; commit byte or flag framing error
  // WAIT_IDLE | after a framing error, waiting for the line to return high
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF_LOAD = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_LOAD = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_IDLE
  } state_t;

  state_t        state, state_nxt;
  logic          rx_meta, rx_sync, rx_prev;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          cnt_zero;
  logic          load_half, load_full, shift_en, commit, frame_err;
  logic          commit_allow;

  assign cnt_zero = (cnt == '0);
  assign busy_o   = (state != IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_meta <= 1'b1;
      rx_sync <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rxd_i;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

`ifdef UART_RX_PARITY_EN
  logic par_err;
  logic par_bad;

  // A bad parity bit poisons the frame; the stop bit is still checked for framing.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      par_bad      <= 1'b0;
      parity_err_o <= 1'b0;
    end else begin
      parity_err_o <= par_err;
      if (load_half)    par_bad <= 1'b0;
      else if (par_err) par_bad <= 1'b1;
    end
  end

  assign commit_allow = !par_bad;
`else
  assign parity_err_o = 1'b0;
  assign commit_allow = 1'b1;
`endif

  always_comb begin
    state_nxt = state;
    load_half = 1'b0;
    load_full = 1'b0;
    shift_en  = 1'b0;
    commit    = 1'b0;
    frame_err = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_nxt = START;
          load_half = 1'b1;
        end
      end
      START: begin
        if (cnt_zero) begin
          if (!rx_sync) begin
            state_nxt = DATA;
            load_full = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      DATA: begin
        if (cnt_zero) begin
          shift_en  = 1'b1;
          load_full = 1'b1;
          if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt_zero) begin
          load_full = 1'b1;
          par_err   = (rx_sync != ^shreg);
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_zero) begin
          if (rx_sync) begin
            commit    = commit_allow;
            state_nxt = IDLE;
          end else begin
            frame_err = 1'b1;
            state_nxt = WAIT_IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (rx_sync) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      bit_idx     <= '0;
      shreg       <= '0;
      data_o      <= '0;
      valid_o     <= 1'b0;
      frame_err_o <= 1'b0;
      overrun_o   <= 1'b0;
    end else begin
      if (load_half)      cnt <= HALF_LOAD;
      else if (load_full) cnt <= FULL_LOAD;
      else if (!cnt_zero) cnt <= cnt - CW'(1);

      if (shift_en) begin
        shreg   <= {rx_sync, shreg[7:1]};
        bit_idx <= bit_idx + 3'd1;
      end

      frame_err_o <= frame_err;
      overrun_o   <= commit && valid_o && !ready_i;
      // A full, unacknowledged holding register keeps its byte; the new one is dropped.
      if (commit && !(valid_o && !ready_i)) begin
        data_o  <= shreg;
        valid_o <= 1'b1;
      end else if (valid_o && ready_i) begin
        valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, meaning clk cycles per UART bit; legal values are 8 or more.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port rxd_i, input, 1 bit: serial line, asynchronous to clk, idle high.
REQ-005 SHALL have port data_o, output, 8 bits: received byte.
REQ-006 SHALL have port valid_o, output, 1 bit: data_o holds an unconsumed byte.
REQ-007 SHALL have port ready_i, input, 1 bit: consumer accepts data_o.
REQ-008 SHALL have port frame_err_o, output, 1 bit: one-cycle pulse when the stop bit is sampled low.
REQ-009 SHALL have port overrun_o, output, 1 bit: one-cycle pulse when a byte is dropped because the holding register is full.
REQ-010 SHALL have port parity_err_o, output, 1 bit: one-cycle pulse on a parity mismatch.
REQ-011 SHALL have port busy_o, output, 1 bit: high in every state except IDLE.

Function
REQ-012 SHALL pass rxd_i through a 2-flop synchronizer; all logic below uses the synchronized value, giving 2 cycles of input latency.
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP and WAIT_IDLE; PARITY exists only per REQ-024.
REQ-014 IDLE: a high-to-low edge on the synchronized line SHALL move the block to START and load the baud counter with CLKS_PER_BIT/2 - 1.
REQ-015 START: when the counter expires, a line still low SHALL move the block to DATA; a high line SHALL return it to IDLE with no outputs asserted (glitch rejection).
REQ-016 DATA: SHALL sample 8 bits, LSB first, each one CLKS_PER_BIT cycles after the previous sample point, using a 3-bit index that wraps 7->0 on leaving.
REQ-017 STOP: the sample is taken CLKS_PER_BIT cycles after the last data or parity sample; a high sample SHALL commit the byte, and a low sample SHALL pulse frame_err_o, discard the byte and enter WAIT_IDLE.
REQ-018 WAIT_IDLE: SHALL stay until the synchronized line is high, then go to IDLE.
REQ-019 Commit: data_o SHALL update and valid_o rise on the clock edge after the stop-bit sample.
REQ-020 Commit with valid_o already high and ready_i low in that same cycle: SHALL pulse overrun_o, drop the new byte and leave data_o unchanged.
REQ-021 Commit in the same cycle as valid_o && ready_i: SHALL take the new byte, keep valid_o high and not pulse overrun_o.
REQ-022 Handshake: valid_o && ready_i SHALL clear valid_o on the next edge when no commit occurs; data_o SHALL stay stable while valid_o is high.

Reset
REQ-023 While reset is low: state = IDLE; data_o = 0x00; valid_o, frame_err_o, overrun_o, parity_err_o and busy_o = 0; counters = 0; synchronizer flops = 1. Reset mid-frame SHALL abandon the frame, and the next start edge after release SHALL be received normally.

Configuration
REQ-024 Macro UART_RX_PARITY_EN:
- Defined: PARITY state follows bit 7 and samples one even-parity bit.
- Mismatch pulses parity_err_o, discards the byte and moves to STOP; the stop sample still checks framing but commits nothing.
- Undefined: frame is 8N1, PARITY state is absent and parity_err_o is tied 0.

Verification (CLKS_PER_BIT=8)
REQ-025 8N1 frame 0xA5, ready_i high -> data_o=0xA5, valid_o high for 1 cycle; no error pulses.
REQ-026 Frames 0x3C then 0x5A, ready_i low -> data_o=0x3C held, valid_o high, overrun_o one pulse at the 0x5A commit.
REQ-027 rxd_i low for 2 cycles, then high -> back to IDLE, valid_o stays 0, busy_o falls 4 cycles after the start detect.
REQ-028 Frame 0x81 with stop bit 0, line held low for 20 cycles -> frame_err_o one pulse, valid_o stays 0, busy_o high until the line returns high; next frame 0x42 received correctly.
REQ-029 reset pulsed low during data bit 4 of 0xFF -> all outputs 0; next frame 0x81 -> data_o=0x81.
REQ-030 With UART_RX_PARITY_EN, frame 0x07 with parity bit 0 -> parity_err_o one pulse, no valid_o; same frame with parity bit 1 -> data_o=0x07.
